// File: rtl/simd_pkg.sv
// Shared opcode encodings, FSM state type and default geometry for the SIMD vector unit.
package simd_pkg;

  localparam int DEF_LANES = 10;
  localparam int DEF_DW    = 16;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MAX  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MIN  = 3'b100;
  localparam logic [2:0] OP_ADDS = 3'b101;
  localparam logic [2:0] OP_SMAX = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/simd_vec_unit_if.sv
// Result stream of the SIMD vector unit: one lane result per valid/ready beat.
interface simd_vec_unit_if
  import simd_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int AW    = $clog2(LANES)
);
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_lane;
  logic [DW-1:0] out_data;

  modport master (output out_valid, output out_lane, output out_data, input out_ready);
  modport slave  (input out_valid, input out_lane, input out_data, output out_ready);
endinterface

// File: rtl/simd_lane_alu.sv
// Combinational per-lane ALU: one opcode applied to a pair of DW-bit operands.
module simd_lane_alu
  import simd_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  input  logic [2:0]    opcode,
  output logic [DW-1:0] result,
  output logic          ovf_lane
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  // The extra top bit of sum/diff is the carry out or the borrow respectively.
  always_comb begin
    sum      = {1'b0, op_a} + {1'b0, op_b};
    diff     = {1'b0, op_a} - {1'b0, op_b};
    result   = '0;
    ovf_lane = 1'b0;
    case (opcode)
      OP_ADD: begin
        result   = sum[DW-1:0];
        ovf_lane = sum[DW];
      end
      OP_MAX:  result = (op_a > op_b) ? op_a : op_b;
      OP_XOR:  result = op_a ^ op_b;
      OP_SUB: begin
        result   = diff[DW-1:0];
        ovf_lane = diff[DW];
      end
      OP_MIN:  result = (op_a < op_b) ? op_a : op_b;
      OP_ADDS: begin
        result   = sum[DW] ? '1 : sum[DW-1:0];
        ovf_lane = sum[DW];
      end
      OP_SMAX: result = ($signed(op_a) > $signed(op_b)) ? op_a : op_b;
      default: begin
        result   = '0;
        ovf_lane = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/simd_vec_unit.sv
// SIMD vector unit: applies one opcode to the first `count` operand lanes, one lane
// per cycle, and streams registered results out on a valid/ready port.
module simd_vec_unit
  import simd_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int AW    = $clog2(LANES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2*DW-1:0] wr_data,
  input  logic            start,
  input  logic [AW:0]     count,
  input  logic [2:0]      opcode,
  output logic            busy,
  output logic            done,
  output logic            ovf,
  simd_vec_unit_if.master out
);

  logic [2*DW-1:0] mem [LANES];
  state_t          state;
  logic [2:0]      op;
  logic [AW:0]     cnt;
  logic [AW-1:0]   lane_idx;
  logic [AW:0]     count_clamped;
  logic [2*DW-1:0] rd_word;
  logic [DW-1:0]   alu_res;
  logic            alu_ovf;
  logic            last_lane;

  assign count_clamped = (count > (AW+1)'(LANES)) ? (AW+1)'(LANES) : count;
  assign rd_word       = mem[lane_idx];
  assign last_lane     = ({1'b0, lane_idx} == (cnt - (AW+1)'(1)));

  simd_lane_alu #(.DW(DW)) u_alu (
    .op_a     (rd_word[2*DW-1:DW]),
    .op_b     (rd_word[DW-1:0]),
    .opcode   (op),
    .result   (alu_res),
    .ovf_lane (alu_ovf)
  );

  // Writes are locked out while busy so an operation always sees a stable operand set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) mem[i] <= '0;
    end else if (wr_en && !busy && ({1'b0, wr_addr} < (AW+1)'(LANES))) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      ovf           <= 1'b0;
      op            <= OP_ADD;
      cnt           <= '0;
      lane_idx      <= '0;
      out.out_valid <= 1'b0;
      out.out_lane  <= '0;
      out.out_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            op       <= opcode;
            cnt      <= count_clamped;
            lane_idx <= '0;
            ovf      <= 1'b0;
          end
        end
        RUN: begin
          // An empty operation passes through RUN for one cycle so busy is still seen.
          if (cnt == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!out.out_valid || out.out_ready) begin
            out.out_valid <= 1'b1;
            out.out_lane  <= lane_idx;
            out.out_data  <= alu_res;
            ovf           <= ovf | alu_ovf;
            if (last_lane) state <= DRAIN;
            else           lane_idx <= lane_idx + AW'(1);
          end
        end
        DRAIN: begin
          if (out.out_valid && out.out_ready) begin
            out.out_valid <= 1'b0;
            state         <= DONE;
            busy          <= 1'b0;
            done          <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_vec_unit.sv
// Directed self-checking bench for simd_vec_unit with hand-computed expected results.
module tb_simd_vec_unit;
  import simd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic [4:0]  count = '0;
  logic [2:0]  opcode = '0;
  logic        busy, done, ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  int          nbeats, done_at, first_valid, valid_cycles, stab_err;
  bit          timed_out;
  logic        busy_k1, ovf_done, busy_at_done;
  logic [3:0]  b_lane [16];
  logic [15:0] b_data [16];
  logic        b_ovf  [16];

  simd_vec_unit_if #(.LANES(10), .DW(16)) vif ();

  simd_vec_unit #(.LANES(10), .DW(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .count   (count),
    .opcode  (opcode),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .out     (vif)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Sample index k is the k-th cycle after the edge that samples start (cycle T+k).
  task automatic run_op(input logic [4:0] c, input logic [2:0] op, input int rmode, input bit inject);
    bit          held;
    logic [3:0]  hl;
    logic [15:0] hd;
    nbeats = 0; done_at = -1; first_valid = -1; valid_cycles = 0; stab_err = 0;
    timed_out = 1'b1; held = 1'b0; hl = '0; hd = '0;
    busy_k1 = 1'b0; ovf_done = 1'b0; busy_at_done = 1'b1;
    @(negedge clk);
    start = 1'b1; count = c; opcode = op; vif.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; count = 5'd3; opcode = OP_RSVD;
    for (int k = 1; k <= 80; k++) begin
      if (k > 1) @(negedge clk);
      vif.out_ready = (rmode == 0) ? 1'b1 : (((k - 1) % 3) == 0);
      if (inject) begin
        if (k == 3) begin
          wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF;
          start = 1'b1; count = 5'd2; opcode = OP_SUB;
        end else begin
          wr_en = 1'b0; start = 1'b0;
        end
      end
      if (k == 1) busy_k1 = busy;
      if (held && (!vif.out_valid || vif.out_lane !== hl || vif.out_data !== hd)) stab_err++;
      held = 1'b0;
      if (vif.out_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = k;
        if (vif.out_ready) begin
          if (nbeats < 16) begin
            b_lane[nbeats] = vif.out_lane;
            b_data[nbeats] = vif.out_data;
            b_ovf[nbeats]  = ovf;
          end
          nbeats++;
        end else begin
          held = 1'b1; hl = vif.out_lane; hd = vif.out_data;
        end
      end
      if (done) begin
        done_at = k; ovf_done = ovf; busy_at_done = busy; timed_out = 1'b0;
        break;
      end
    end
    wr_en = 1'b0; start = 1'b0; vif.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    vif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("[TB] FAIL reset_ovf: got %b want 0", ovf); else pass_cnt++;
    total_cnt++; if (vif.out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", vif.out_valid); else pass_cnt++;
    total_cnt++; if (vif.out_lane !== 4'd0) $display("[TB] FAIL reset_lane: got %h want 0", vif.out_lane); else pass_cnt++;
    total_cnt++; if (vif.out_data !== 16'd0) $display("[TB] FAIL reset_data: got %h want 0", vif.out_data); else pass_cnt++;
  endtask

  task automatic test_add();
    load(4'd0, {16'h0003, 16'h0005});
    load(4'd1, {16'hFFFF, 16'h0002});
    run_op(5'd2, OP_ADD, 0, 1'b0);
    total_cnt++; if (timed_out) $display("[TB] FAIL add_timeout: no done within bound"); else pass_cnt++;
    total_cnt++; if (busy_k1 !== 1'b1) $display("[TB] FAIL add_busy_t1: got %b want 1", busy_k1); else pass_cnt++;
    total_cnt++; if (first_valid != 2) $display("[TB] FAIL add_first_valid: got T+%0d want T+2", first_valid); else pass_cnt++;
    total_cnt++; if (nbeats != 2) $display("[TB] FAIL add_beats: got %0d want 2", nbeats); else pass_cnt++;
    total_cnt++; if (b_lane[0] !== 4'd0 || b_data[0] !== 16'h0008) $display("[TB] FAIL add_beat0: got (%h,%h) want (0,0008)", b_lane[0], b_data[0]); else pass_cnt++;
    total_cnt++; if (b_lane[1] !== 4'd1 || b_data[1] !== 16'h0001) $display("[TB] FAIL add_beat1: got (%h,%h) want (1,0001)", b_lane[1], b_data[1]); else pass_cnt++;
    total_cnt++; if (b_ovf[0] !== 1'b0 || b_ovf[1] !== 1'b1) $display("[TB] FAIL add_ovf_timing: got %b%b want 01", b_ovf[0], b_ovf[1]); else pass_cnt++;
    total_cnt++; if (done_at != 4) $display("[TB] FAIL add_done_cycle: got T+%0d want T+4", done_at); else pass_cnt++;
    total_cnt++; if (busy_at_done !== 1'b0) $display("[TB] FAIL add_busy_at_done: got %b want 0", busy_at_done); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ovf !== 1'b1) $display("[TB] FAIL add_ovf_sticky: got %b want 1", ovf); else pass_cnt++;
  endtask

  task automatic test_opcodes();
    logic [2:0]  ops  [6] = '{OP_ADDS, OP_MAX, OP_SMAX, OP_XOR, OP_SUB, OP_MIN};
    logic [15:0] exp0 [6] = '{16'h0008, 16'h0005, 16'h0005, 16'h0006, 16'hFFFE, 16'h0003};
    logic [15:0] exp1 [6] = '{16'hFFFF, 16'hFFFF, 16'h0002, 16'hFFFD, 16'hFFFD, 16'h0002};
    logic        expo [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      run_op(5'd2, ops[i], 0, 1'b0);
      total_cnt++;
      if (timed_out || nbeats != 2 || b_data[0] !== exp0[i] || b_data[1] !== exp1[i])
        $display("[TB] FAIL op%0d_results: got %0d beats (%h,%h) want 2 beats (%h,%h)", ops[i], nbeats, b_data[0], b_data[1], exp0[i], exp1[i]);
      else pass_cnt++;
      total_cnt++;
      if (ovf_done !== expo[i]) $display("[TB] FAIL op%0d_ovf: got %b want %b", ops[i], ovf_done, expo[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) load(4'(i), {16'h0100 * 16'(i), 16'(i)});
    run_op(5'd10, OP_ADD, 1, 1'b0);
    total_cnt++; if (timed_out) $display("[TB] FAIL bp_timeout: no done within bound"); else pass_cnt++;
    total_cnt++; if (nbeats != 10) $display("[TB] FAIL bp_beats: got %0d want 10", nbeats); else pass_cnt++;
    total_cnt++; if (stab_err != 0) $display("[TB] FAIL bp_stable: got %0d unstable stalls want 0", stab_err); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      total_cnt++;
      if (b_lane[i] !== 4'(i) || b_data[i] !== 16'h0101 * 16'(i))
        $display("[TB] FAIL bp_beat%0d: got (%h,%h) want (%h,%h)", i, b_lane[i], b_data[i], 4'(i), 16'h0101 * 16'(i));
      else pass_cnt++;
    end
    total_cnt++; if (ovf_done !== 1'b0) $display("[TB] FAIL bp_ovf: got %b want 0", ovf_done); else pass_cnt++;
  endtask

  task automatic test_count_edges();
    run_op(5'd0, OP_ADD, 0, 1'b0);
    total_cnt++; if (busy_k1 !== 1'b1) $display("[TB] FAIL cnt0_busy_t1: got %b want 1", busy_k1); else pass_cnt++;
    total_cnt++; if (done_at != 2) $display("[TB] FAIL cnt0_done_cycle: got T+%0d want T+2", done_at); else pass_cnt++;
    total_cnt++; if (valid_cycles != 0) $display("[TB] FAIL cnt0_no_valid: got %0d valid cycles want 0", valid_cycles); else pass_cnt++;
    run_op(5'd15, OP_ADD, 0, 1'b0);
    total_cnt++; if (nbeats != 10) $display("[TB] FAIL cnt15_beats: got %0d want 10", nbeats); else pass_cnt++;
    total_cnt++; if (done_at != 12) $display("[TB] FAIL cnt15_done_cycle: got T+%0d want T+12", done_at); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    run_op(5'd10, OP_ADD, 0, 1'b1);
    total_cnt++; if (nbeats != 10 || done_at != 12) $display("[TB] FAIL busy_start_ignored: got %0d beats done T+%0d want 10 beats done T+12", nbeats, done_at); else pass_cnt++;
    total_cnt++; if (b_data[3] !== 16'h0303) $display("[TB] FAIL busy_write_inflight: got %h want 0303", b_data[3]); else pass_cnt++;
    run_op(5'd10, OP_ADD, 0, 1'b0);
    total_cnt++; if (b_data[3] !== 16'h0303 || b_data[9] !== 16'h0909) $display("[TB] FAIL busy_write_rerun: got %h,%h want 0303,0909", b_data[3], b_data[9]); else pass_cnt++;
    run_op(5'd10, OP_RSVD, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      total_cnt++;
      if (b_data[i] !== 16'h0000) $display("[TB] FAIL rsvd_beat%0d: got %h want 0000", i, b_data[i]); else pass_cnt++;
    end
    total_cnt++; if (ovf_done !== 1'b1) $display("[TB] FAIL rsvd_ovf: got %b want 1", ovf_done); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int  accepted;
    bit  reached;
    accepted = 0; reached = 1'b0;
    @(negedge clk);
    start = 1'b1; count = 5'd10; opcode = OP_ADD; vif.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      vif.out_ready = (accepted < 4);
      if (vif.out_valid && !vif.out_ready && vif.out_lane == 4'd4) begin
        reached = 1'b1;
        break;
      end
      if (vif.out_valid && vif.out_ready) accepted++;
    end
    total_cnt++; if (!reached) $display("[TB] FAIL abort_stall_lane4: stall at lane 4 not reached, accepted %0d", accepted); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0 || vif.out_valid !== 1'b0) $display("[TB] FAIL abort_immediate: busy %b valid %b want 0 0", busy, vif.out_valid); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("[TB] FAIL abort_no_done: got %b want 0", done); else pass_cnt++;
    @(negedge clk);
    vif.out_ready = 1'b1;
    rst_n = 1'b1;
    run_op(5'd10, OP_ADD, 0, 1'b0);
    total_cnt++; if (nbeats != 10 || done_at != 12) $display("[TB] FAIL abort_rerun: got %0d beats done T+%0d want 10 beats done T+12", nbeats, done_at); else pass_cnt++;
    total_cnt++; if (b_data[5] !== 16'h0000 || b_data[9] !== 16'h0000 || ovf_done !== 1'b0) $display("[TB] FAIL abort_mem_cleared: got %h,%h ovf %b want 0000,0000 ovf 0", b_data[5], b_data[9], ovf_done); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_opcodes();
    test_backpressure();
    test_count_edges();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
